// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and one-hot helper.
// Optional feature macro used by this slice: FIFO_ARB_HIPRI_EN (see fifo_arb_rr_pick).
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StBurst = ST_BURST
    } state_e;

    localparam int unsigned OneHotMaxW = 32;

    // Callers cast the result down to their own requester count.
    function automatic logic [OneHotMaxW-1:0] onehot(input int unsigned idx);
        return {{(OneHotMaxW-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: picks the first requester after i_last_idx, with wrap.
// Macro FIFO_ARB_HIPRI_EN: when defined, requester 0 overrides the round-robin pick.
module fifo_arb_rr_pick #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last_idx,
    output logic [IDX_WIDTH-1:0] o_pick_idx,
    output logic                 o_pick_valid
);

    // Scan last+1, last+2, ... and keep the first hit; the last requester served is scanned last.
    always_comb begin
        int unsigned w_idx;
        o_pick_idx   = '0;
        o_pick_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = (32'(i_last_idx) + k) % NUM_REQ;
            if (!o_pick_valid && i_req[IDX_WIDTH'(w_idx)]) begin
                o_pick_idx   = IDX_WIDTH'(w_idx);
                o_pick_valid = 1'b1;
            end
        end
`ifdef FIFO_ARB_HIPRI_EN
        if (i_req[0]) begin
            o_pick_idx   = '0;
            o_pick_valid = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ writers.
// Grant and busy are registered; write enable and data are combinational from the grant.
// Macro FIFO_ARB_HIPRI_EN: requester 0 wins every new arbitration (no preemption).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_w_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
    output logic                          o_busy
);

    localparam logic [CNT_WIDTH-1:0] CntLast  = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [IDX_WIDTH-1:0] LastInit = IDX_WIDTH'(NUM_REQ - 1);

    state_e                 r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [IDX_WIDTH-1:0]   r_grant_idx;
    logic                   r_busy;
    logic [CNT_WIDTH-1:0]   r_burst_cnt;
    logic [IDX_WIDTH-1:0]   r_last_idx;

    logic [IDX_WIDTH-1:0]   w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_acc;
    logic                   w_req_g;
    logic [DATA_WIDTH-1:0]  w_data;

    fifo_arb_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req        (i_req),
        .i_last_idx   (r_last_idx),
        .o_pick_idx   (w_pick_idx),
        .o_pick_valid (w_pick_valid)
    );

    // Grant is zero outside a burst, so this alone keeps IDLE write-free.
    assign w_acc   = (|(r_grant & i_req)) & ~i_fifo_full & ~i_rst;
    assign w_req_g = i_req[r_grant_idx];

    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_fifo_w_en = w_acc;

    // Write mux: OR of the granted slice; all-zero grant yields zero data.
    always_comb begin
        w_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_data = w_data | i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_fifo_data_in = w_data;

    // Arbitration FSM: IDLE grants the rotating pick, BURST runs until the cap or a req drop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_burst_cnt <= '0;
            r_last_idx  <= LastInit;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_state     <= StBurst;
                        r_grant     <= NUM_REQ'(onehot(32'(w_pick_idx)));
                        r_grant_idx <= w_pick_idx;
                        r_busy      <= 1'b1;
                        r_burst_cnt <= '0;
                    end
                end
                StBurst: begin
                    // A full FIFO only stalls; it never releases unless req itself drops.
                    if (!w_req_g || (w_acc && r_burst_cnt == CntLast)) begin
                        r_state     <= StIdle;
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_burst_cnt <= '0;
                        r_last_idx  <= r_grant_idx;
                    end else if (w_acc) begin
                        r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, directed corner cases and
// randomized traffic, all compared against a transaction-level owner/word-count model.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int IDX_WIDTH  = 2;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int CNT_WIDTH  = 3;

    logic                          clk = 1'b0;
    logic                          i_rst;
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_grant;
    logic                          i_fifo_full;
    logic                          o_fifo_w_en;
    logic [DATA_WIDTH-1:0]         o_fifo_data_in;
    logic                          o_busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .IDX_WIDTH  (IDX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_req_data     (i_req_data),
        .o_grant        (o_grant),
        .i_fifo_full    (i_fifo_full),
        .o_fifo_w_en    (o_fifo_w_en),
        .o_fifo_data_in (o_fifo_data_in),
        .o_busy         (o_busy)
    );

    // Each requester presents its current word; it advances only after being written.
    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) i_req_data[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
    end

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: who owns the port (-1 = nobody), words it has written, last owner served.
    int m_owner;
    int m_words;
    int m_last;

    logic [NUM_REQ-1:0]    obs_grant;
    logic                  obs_wen;
    logic                  obs_busy;
    logic [DATA_WIDTH-1:0] obs_data;

    typedef struct {
        logic                  rst;
        logic [NUM_REQ-1:0]    req;
        logic                  full;
        logic [NUM_REQ-1:0]    g;
        logic                  wen;
        logic                  busy;
        logic [DATA_WIDTH-1:0] data;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] req, input int last);
`ifdef FIFO_ARB_HIPRI_EN
        if (req[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] g);
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic init_words();
        for (int i = 0; i < NUM_REQ; i++) words[i] = DATA_WIDTH'(i * 16);
    endtask

    // One clock: drive after the falling edge, sample 1 ns later, then advance the model.
    task automatic cycle(input logic rst, input logic [NUM_REQ-1:0] req, input logic full);
        logic [NUM_REQ-1:0]    eg;
        logic                  eb;
        logic                  ew;
        logic [DATA_WIDTH-1:0] ed;
        int                    p;
        @(negedge clk);
        i_rst       = rst;
        i_req       = req;
        i_fifo_full = full;
        #1;
        obs_grant = o_grant;
        obs_wen   = o_fifo_w_en;
        obs_busy  = o_busy;
        obs_data  = o_fifo_data_in;
        eb = (m_owner >= 0);
        eg = eb ? NUM_REQ'(1 << m_owner) : '0;
        ed = eb ? words[m_owner] : '0;
        ew = 1'b0;
        if (eb) ew = req[m_owner] && !full && !rst;
        if (check_en) begin
            check("model_grant", 32'(obs_grant), 32'(eg));
            check("model_busy", 32'(obs_busy), 32'(eb));
            check("model_wen", 32'(obs_wen), 32'(ew));
            check("model_data", 32'(obs_data), 32'(ed));
        end
        if (ew) words[m_owner] = words[m_owner] + 1'b1;
        if (rst) begin
            m_owner = -1;
            m_words = 0;
            m_last  = NUM_REQ - 1;
        end else if (m_owner < 0) begin
            p = model_pick(req, m_last);
            if (p >= 0) begin
                m_owner = p;
                m_words = 0;
            end
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (ew) begin
            m_words++;
            if (m_words == MAX_BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, '0, 1'b0);
        cycle(1'b1, '0, 1'b0);
        init_words();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wc;
        int got;
        int order[$];
        int exp_order [5];
        logic [NUM_REQ-1:0] prevg;
        logic [NUM_REQ-1:0] rq;

        i_rst = 1'b1;
        i_req = '0;
        i_fifo_full = 1'b0;
        m_owner = -1;
        m_words = 0;
        m_last = NUM_REQ - 1;
        init_words();

        // Request 1 alone for six words: 4-word burst, dead cycle, 2 more, release on drop.
        tbl[0] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h10};
        tbl[2] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h12};
        tbl[4] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h13};
        tbl[5] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h14};
        tbl[7] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h15};
        tbl[8] = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 8'h16};
        tbl[9] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};

        cycle(1'b1, '0, 1'b0);
        check_en = 1'b1;
        do_reset();

        // Reset state, with the FIFO full to show nothing leaks through.
        cycle(1'b0, 4'b0000, 1'b1);
        check("rst_grant", 32'(obs_grant), 32'h0);
        check("rst_busy", 32'(obs_busy), 32'h0);
        check("rst_wen", 32'(obs_wen), 32'h0);

        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(tbl[k].rst, tbl[k].req, tbl[k].full);
            check($sformatf("tbl%0d_grant", k), 32'(obs_grant), 32'(tbl[k].g));
            check($sformatf("tbl%0d_wen", k), 32'(obs_wen), 32'(tbl[k].wen));
            check($sformatf("tbl%0d_busy", k), 32'(obs_busy), 32'(tbl[k].busy));
            check($sformatf("tbl%0d_data", k), 32'(obs_data), 32'(tbl[k].data));
        end

        // All requesters busy: rotation order and 4 writes in every 5 cycles.
        do_reset();
        wc = 0;
        prevg = '0;
        order.delete();
        for (int c = 0; c < 25; c++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            if (obs_wen) wc++;
            if (obs_grant != 0 && prevg == 0) order.push_back(idx_of(obs_grant));
            prevg = obs_grant;
        end
        check("t2_writes", 32'(wc), 32'd20);
`ifdef FIFO_ARB_HIPRI_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            check($sformatf("t2_order%0d", k), 32'(got), 32'(exp_order[k]));
        end

        // FIFO full for 3 cycles after the second word: stall, resume, exactly 4 words.
        do_reset();
        wc = 0;
        for (int c = 0; c < 9; c++) begin
            cycle(1'b0, 4'b0001, (c >= 3 && c <= 5));
            if (obs_wen) wc++;
            if (c == 4) check("t3_grant_held", 32'(obs_grant), 32'h1);
            if (c == 8) check("t3_released", 32'(obs_grant), 32'h0);
        end
        check("t3_writes", 32'(wc), 32'd4);

        // Request 1 drops after two words while 2 and 3 wait: next grant is 2.
        do_reset();
        repeat (3) cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b1100, 1'b0);
        check("t4_drop_wen", 32'(obs_wen), 32'h0);
        cycle(1'b0, 4'b1100, 1'b0);
        check("t4_cleared", 32'(obs_grant), 32'h0);
        cycle(1'b0, 4'b1100, 1'b0);
        check("t4_next", 32'(obs_grant), 32'h4);

        // Reset in the middle of a burst to requester 2.
        do_reset();
        cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        check("t5_grant", 32'(obs_grant), 32'h4);
        cycle(1'b1, 4'b1010, 1'b0);
        check("t5_rst_wen", 32'(obs_wen), 32'h0);
        cycle(1'b0, 4'b1010, 1'b0);
        check("t5_cleared", 32'(obs_grant), 32'h0);
        cycle(1'b0, 4'b1010, 1'b0);
        check("t5_next", 32'(obs_grant), 32'h2);

        // last_idx = 0 with requests 0 and 2 pending.
        do_reset();
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0101, 1'b0);
        cycle(1'b0, 4'b0101, 1'b0);
`ifdef FIFO_ARB_HIPRI_EN
        check("t6_pick", 32'(obs_grant), 32'h1);
`else
        check("t6_pick", 32'(obs_grant), 32'h4);
`endif

        // Randomized traffic with occasional full and reset.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) rq[i] = ($urandom_range(0, 4) != 0);
            cycle(($urandom_range(0, 59) == 0), rq, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
